// File: rtl/l1d_tag_stage.sv
// ---------------------------------------------------------------------------
// l1d_tag_stage
//
// Tag-lookup stage of the L1 data cache pipeline. It takes an instruction from
// operand fetch, forms the effective address (lane 0 for ordinary accesses, or
// the scatter/gather lane picked by the subcycle), and looks the address up in
// a flop-based tag store (NUM_SETS x NUM_WAYS of {valid, tag}). One cycle
// later it presents the address, hit information, the round-robin victim way
// for the set, and pipelined copies of the mask, store data, thread and
// subcycle.
//
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   of_*                     instruction from operand fetch
//   wb_rollback_en/_thread   squashes the incoming instruction of that thread
//   fill_en/_set/_way/_tag   L2 fill writes {1, tag} into the tag store
//   inval_all                clears every valid bit (wins over a fill)
//   dt_*                     registered stage outputs, 1-cycle latency
// ---------------------------------------------------------------------------
module l1d_tag_stage #(
    parameter int NUM_LANES   = 16,
    parameter int NUM_WAYS    = 4,
    parameter int NUM_SETS    = 64,
    parameter int LINE_BYTES  = 64,
    parameter int NUM_THREADS = 4,
    localparam int OFS  = $clog2(LINE_BYTES),
    localparam int IDX  = $clog2(NUM_SETS),
    localparam int TAGW = 32 - IDX - OFS,
    localparam int TIDW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int SCW  = $clog2(NUM_LANES),
    localparam int WAYW = $clog2(NUM_WAYS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    of_instruction_valid,
    input  logic                    of_is_mem,
    input  logic                    of_is_scgath,
    input  logic [NUM_LANES*32-1:0] of_operand1,
    input  logic [31:0]             of_immediate,
    input  logic [SCW-1:0]          of_subcycle,
    input  logic [TIDW-1:0]         of_thread_idx,
    input  logic [NUM_LANES-1:0]    of_mask_value,
    input  logic [NUM_LANES*32-1:0] of_store_value,
    input  logic                    wb_rollback_en,
    input  logic [TIDW-1:0]         wb_rollback_thread_idx,
    input  logic                    fill_en,
    input  logic [IDX-1:0]          fill_set,
    input  logic [WAYW-1:0]         fill_way,
    input  logic [TAGW-1:0]         fill_tag,
    input  logic                    inval_all,
    output logic                    dt_instruction_valid,
    output logic [31:0]             dt_request_addr,
    output logic                    dt_hit,
    output logic [NUM_WAYS-1:0]     dt_hit_way_oh,
    output logic [WAYW-1:0]         dt_victim_way,
    output logic [NUM_LANES-1:0]    dt_mask_value,
    output logic [NUM_LANES*32-1:0] dt_store_value,
    output logic [TIDW-1:0]         dt_thread_idx,
    output logic [SCW-1:0]          dt_subcycle
);

    // Tag store and per-set replacement counters.
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] valid_d  [NUM_SETS];
    logic [TAGW-1:0]     tag_q    [NUM_SETS][NUM_WAYS];
    logic [TAGW-1:0]     tag_d    [NUM_SETS][NUM_WAYS];
    logic [WAYW-1:0]     victim_q [NUM_SETS];
    logic [WAYW-1:0]     victim_d [NUM_SETS];

    // Output pipeline registers.
    logic                    inst_valid_q, inst_valid_d;
    logic [31:0]             addr_q, addr_d;
    logic                    hit_q, hit_d;
    logic [NUM_WAYS-1:0]     hit_oh_q, hit_oh_d;
    logic [WAYW-1:0]         victim_way_q, victim_way_d;
    logic [NUM_LANES-1:0]    mask_q;
    logic [NUM_LANES*32-1:0] store_q;
    logic [TIDW-1:0]         thread_q;
    logic [SCW-1:0]          subcycle_q;

    logic [SCW-1:0]  lane_sel;
    logic [31:0]     base_addr;
    logic [TAGW-1:0] lk_tag;
    logic [IDX-1:0]  lk_set;

    // Address generation. Scatter/gather walks lanes from the top down, so
    // subcycle 0 uses the highest lane.
    always_comb begin
        lane_sel  = SCW'(NUM_LANES - 1) - of_subcycle;
        base_addr = of_is_scgath ? of_operand1[lane_sel*32 +: 32] : of_operand1[31:0];
        addr_d    = base_addr + of_immediate;
        lk_tag    = addr_d[31:IDX+OFS];
        lk_set    = addr_d[IDX+OFS-1:OFS];
    end

    // Lookup. A same-cycle fill to the looked-up entry is forwarded so the
    // lookup sees the post-fill contents; a concurrent inval_all forces a miss.
    always_comb begin
        logic            way_valid;
        logic [TAGW-1:0] way_tag;
        inst_valid_d = of_instruction_valid && of_is_mem &&
                       !(wb_rollback_en && (wb_rollback_thread_idx == of_thread_idx));
        hit_oh_d     = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_valid = valid_q[lk_set][w];
            way_tag   = tag_q[lk_set][w];
            if (fill_en && (fill_set == lk_set) && (fill_way == WAYW'(w))) begin
                way_valid = 1'b1;
                way_tag   = fill_tag;
            end
            hit_oh_d[w] = inst_valid_d && !inval_all && way_valid && (way_tag == lk_tag);
        end
        hit_d        = |hit_oh_d;
        victim_way_d = victim_q[lk_set];
    end

    // Tag store update. inval_all clears valid bits after the fill is applied,
    // so a same-cycle fill ends up invalid; the tag and counter still update.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        victim_d = victim_q;
        if (fill_en && !reset) begin
            valid_d[fill_set][fill_way] = 1'b1;
            tag_d[fill_set][fill_way]   = fill_tag;
            victim_d[fill_set]          = victim_q[fill_set] + WAYW'(1);
        end
        if (inval_all) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_d[s] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s]  <= '0;
                victim_q[s] <= '0;
            end
            inst_valid_q <= 1'b0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            hit_oh_q     <= '0;
            victim_way_q <= '0;
            mask_q       <= '0;
            store_q      <= '0;
            thread_q     <= '0;
            subcycle_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            victim_q     <= victim_d;
            inst_valid_q <= inst_valid_d;
            addr_q       <= addr_d;
            hit_q        <= hit_d;
            hit_oh_q     <= hit_oh_d;
            victim_way_q <= victim_way_d;
            mask_q       <= of_mask_value;
            store_q      <= of_store_value;
            thread_q     <= of_thread_idx;
            subcycle_q   <= of_subcycle;
        end
    end

    // Tag contents carry no reset; writes are blocked while reset is high.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

    assign dt_instruction_valid = inst_valid_q;
    assign dt_request_addr      = addr_q;
    assign dt_hit               = hit_q;
    assign dt_hit_way_oh        = hit_oh_q;
    assign dt_victim_way        = victim_way_q;
    assign dt_mask_value        = mask_q;
    assign dt_store_value       = store_q;
    assign dt_thread_idx        = thread_q;
    assign dt_subcycle          = subcycle_q;

endmodule

// File: tb/tb_l1d_tag_stage.sv
module tb_l1d_tag_stage;

  localparam int NUM_LANES = 16;

  logic                    clk;
  logic                    reset;
  logic                    of_instruction_valid;
  logic                    of_is_mem;
  logic                    of_is_scgath;
  logic [NUM_LANES*32-1:0] of_operand1;
  logic [31:0]             of_immediate;
  logic [3:0]              of_subcycle;
  logic [1:0]              of_thread_idx;
  logic [NUM_LANES-1:0]    of_mask_value;
  logic [NUM_LANES*32-1:0] of_store_value;
  logic                    wb_rollback_en;
  logic [1:0]              wb_rollback_thread_idx;
  logic                    fill_en;
  logic [5:0]              fill_set;
  logic [1:0]              fill_way;
  logic [19:0]             fill_tag;
  logic                    inval_all;
  logic                    dt_instruction_valid;
  logic [31:0]             dt_request_addr;
  logic                    dt_hit;
  logic [3:0]              dt_hit_way_oh;
  logic [1:0]              dt_victim_way;
  logic [NUM_LANES-1:0]    dt_mask_value;
  logic [NUM_LANES*32-1:0] dt_store_value;
  logic [1:0]              dt_thread_idx;
  logic [3:0]              dt_subcycle;

  int n_assert = 0;
  int n_fail   = 0;

  l1d_tag_stage dut (
    .clk                    (clk),
    .reset                  (reset),
    .of_instruction_valid   (of_instruction_valid),
    .of_is_mem              (of_is_mem),
    .of_is_scgath           (of_is_scgath),
    .of_operand1            (of_operand1),
    .of_immediate           (of_immediate),
    .of_subcycle            (of_subcycle),
    .of_thread_idx          (of_thread_idx),
    .of_mask_value          (of_mask_value),
    .of_store_value         (of_store_value),
    .wb_rollback_en         (wb_rollback_en),
    .wb_rollback_thread_idx (wb_rollback_thread_idx),
    .fill_en                (fill_en),
    .fill_set               (fill_set),
    .fill_way               (fill_way),
    .fill_tag               (fill_tag),
    .inval_all              (inval_all),
    .dt_instruction_valid   (dt_instruction_valid),
    .dt_request_addr        (dt_request_addr),
    .dt_hit                 (dt_hit),
    .dt_hit_way_oh          (dt_hit_way_oh),
    .dt_victim_way          (dt_victim_way),
    .dt_mask_value          (dt_mask_value),
    .dt_store_value         (dt_store_value),
    .dt_thread_idx          (dt_thread_idx),
    .dt_subcycle            (dt_subcycle)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    of_instruction_valid   = 1'b0;
    of_is_mem              = 1'b0;
    of_is_scgath           = 1'b0;
    of_operand1            = '0;
    of_immediate           = '0;
    of_subcycle            = '0;
    of_thread_idx          = '0;
    of_mask_value          = '0;
    of_store_value         = '0;
    wb_rollback_en         = 1'b0;
    wb_rollback_thread_idx = '0;
    fill_en                = 1'b0;
    fill_set               = '0;
    fill_way               = '0;
    fill_tag               = '0;
    inval_all              = 1'b0;
  endtask

  // plain load whose lane 0 base is addr, immediate 0
  task automatic load(input logic [31:0] addr);
    of_instruction_valid = 1'b1;
    of_is_mem            = 1'b1;
    of_is_scgath         = 1'b0;
    of_operand1          = '0;
    of_operand1[31:0]    = addr;
    of_immediate         = '0;
  endtask

  task automatic fill(input logic [5:0] s, input logic [1:0] w, input logic [19:0] t);
    fill_en  = 1'b1;
    fill_set = s;
    fill_way = w;
    fill_tag = t;
  endtask

  initial begin
    idle();
    // reset, with a fill attempted (must be ignored)
    reset = 1'b1;
    tick();
    fill(6'd1, 2'd2, 20'h00001);
    load(32'h0000_1040);
    tick();
    check("rst_valid", 32'(dt_instruction_valid), 32'd0);
    check("rst_addr",  dt_request_addr, 32'h0);
    check("rst_hit",   32'(dt_hit), 32'd0);
    check("rst_victim", 32'(dt_victim_way), 32'd0);
    idle();
    reset = 1'b0;
    // fill during reset left set 1 empty and counter at 0
    load(32'h0000_1040);
    tick();
    check("rst_fill_ignored_hit", 32'(dt_hit), 32'd0);
    check("rst_fill_ignored_victim", 32'(dt_victim_way), 32'd0);

    // fill then load hits
    idle();
    fill(6'd1, 2'd2, 20'h00001);
    tick();
    idle();
    load(32'h0000_1000);
    of_immediate   = 32'h40;
    of_mask_value  = 16'hA5C3;
    of_store_value[31:0] = 32'hDEAD_BEEF;
    of_thread_idx  = 2'd3;
    of_subcycle    = 4'd9;
    tick();
    check("ld_valid",  32'(dt_instruction_valid), 32'd1);
    check("ld_addr",   dt_request_addr, 32'h0000_1040);
    check("ld_hit",    32'(dt_hit), 32'd1);
    check("ld_oh",     32'(dt_hit_way_oh), 32'b0100);
    check("ld_victim", 32'(dt_victim_way), 32'd1);
    check("ld_mask",   32'(dt_mask_value), 32'hA5C3);
    check("ld_store",  dt_store_value[31:0], 32'hDEAD_BEEF);
    check("ld_thread", 32'(dt_thread_idx), 32'd3);
    check("ld_subcyc", 32'(dt_subcycle), 32'd9);

    // scatter/gather lane select: subcycle 3 -> lane 12
    idle();
    of_instruction_valid = 1'b1;
    of_is_mem            = 1'b1;
    of_is_scgath         = 1'b1;
    of_subcycle          = 4'd3;
    for (int i = 0; i < NUM_LANES; i++) of_operand1[32*i +: 32] = 32'h0100_0000 + 32'(i);
    of_operand1[32*12 +: 32] = 32'h0000_2000;
    of_immediate         = 32'h4;
    tick();
    check("sg_addr",   dt_request_addr, 32'h0000_2004);
    check("sg_hit",    32'(dt_hit), 32'd0);
    check("sg_victim", 32'(dt_victim_way), 32'd0);

    // round-robin victim on set 5, fills concurrent with lookups
    for (int k = 0; k < 4; k++) begin
      idle();
      fill(6'd5, 2'(k), 20'h00010 + 20'(k));
      load(32'h0000_0140);
      tick();
      check("rr_victim", 32'(dt_victim_way), 32'(k));
      check("rr_miss",   32'(dt_hit), 32'd0);
    end
    idle();
    load(32'h0001_2140);
    tick();
    check("rr_wrap", 32'(dt_victim_way), 32'd0);
    check("rr_hit",  32'(dt_hit), 32'd1);
    check("rr_oh",   32'(dt_hit_way_oh), 32'b0100);

    // same-cycle fill bypass
    idle();
    fill(6'd1, 2'd3, 20'h00007);
    load(32'h0000_7040);
    tick();
    check("byp_hit", 32'(dt_hit), 32'd1);
    check("byp_oh",  32'(dt_hit_way_oh), 32'b1000);
    check("byp_victim", 32'(dt_victim_way), 32'd1);

    // same case with inval_all
    idle();
    fill(6'd1, 2'd0, 20'h00008);
    inval_all = 1'b1;
    load(32'h0000_8040);
    tick();
    check("inv_hit", 32'(dt_hit), 32'd0);
    check("inv_oh",  32'(dt_hit_way_oh), 32'd0);
    check("inv_valid", 32'(dt_instruction_valid), 32'd1);
    idle();
    load(32'h0000_8040);
    tick();
    check("inv_fill_dead", 32'(dt_hit), 32'd0);
    idle();
    load(32'h0000_1040);
    tick();
    check("inv_cleared", 32'(dt_hit), 32'd0);
    check("inv_cnt_kept", 32'(dt_victim_way), 32'd3);

    // rollback
    idle();
    fill(6'd2, 2'd1, 20'h00003);
    tick();
    idle();
    load(32'h0000_3080);
    of_thread_idx          = 2'd2;
    wb_rollback_en         = 1'b1;
    wb_rollback_thread_idx = 2'd2;
    tick();
    check("rb_match_valid", 32'(dt_instruction_valid), 32'd0);
    check("rb_match_hit",   32'(dt_hit), 32'd0);
    check("rb_match_oh",    32'(dt_hit_way_oh), 32'd0);
    wb_rollback_thread_idx = 2'd1;
    tick();
    check("rb_other_valid", 32'(dt_instruction_valid), 32'd1);
    check("rb_other_hit",   32'(dt_hit), 32'd1);
    check("rb_other_oh",    32'(dt_hit_way_oh), 32'b0010);

    // non-memory instruction
    idle();
    of_instruction_valid = 1'b1;
    of_operand1[31:0]    = 32'h0000_3080;
    tick();
    check("nomem_valid", 32'(dt_instruction_valid), 32'd0);
    check("nomem_hit",   32'(dt_hit), 32'd0);

    // mid-stream reset
    idle();
    fill(6'd3, 2'd0, 20'h00055);
    tick();
    idle();
    load(32'h0005_50C0);
    of_mask_value = 16'hFFFF;
    reset = 1'b1;
    fill(6'd3, 2'd1, 20'h00055);
    tick();
    check("mrst_valid", 32'(dt_instruction_valid), 32'd0);
    check("mrst_addr",  dt_request_addr, 32'h0);
    check("mrst_hit",   32'(dt_hit), 32'd0);
    check("mrst_oh",    32'(dt_hit_way_oh), 32'd0);
    check("mrst_mask",  32'(dt_mask_value), 32'd0);
    idle();
    reset = 1'b0;
    load(32'h0005_50C0);
    tick();
    check("post_rst_valid",  32'(dt_instruction_valid), 32'd1);
    check("post_rst_hit",    32'(dt_hit), 32'd0);
    check("post_rst_victim", 32'(dt_victim_way), 32'd0);
    idle();
    tick();
    check("idle_valid", 32'(dt_instruction_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
